// File: rtl/ifetch_unit_pkg.sv
// Shared control encodings for the instruction fetch stage.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    IF_S_FETCH = 2'd0,
    IF_S_HOLD  = 2'd1,
    IF_S_ERR   = 2'd2
  } if_state_e;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register: asynchronous reset to ResetPc, loads d when load is high.
module fetch_pc_reg
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] ResetPc = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= ResetPc;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, fetches over req/ack, hands instructions to decode via valid/ready.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      npc,
  output logic [31:0]      pc_o,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_instr,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired_cnt
);

  if_state_e        state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_load;

  fetch_pc_reg #(
    .ResetPc (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rstn (rstn),
    .load (pc_load),
    .d    (npc),
    .q    (pc_o)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    pc_load = 1'b0;
    unique case (state_q)
      IF_S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = IF_S_HOLD;
        end
      end
      IF_S_HOLD: begin
        if (if_ready) begin
          pc_load = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          // The misaligned target still lands in the PC so it is visible for debug.
          state_d = (npc[1:0] == 2'b00) ? IF_S_FETCH : IF_S_ERR;
        end
      end
      IF_S_ERR: begin
        state_d = IF_S_ERR;
      end
      default: begin
        state_d = IF_S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IF_S_FETCH;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gate with rstn so an in-flight request drops the moment reset asserts.
  assign imem_req    = rstn && (state_q == IF_S_FETCH);
  assign if_valid    = rstn && (state_q == IF_S_HOLD);
  assign fetch_err   = (state_q == IF_S_ERR);
  assign imem_addr   = pc_o;
  assign if_instr    = instr_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a full-width counter instance and a 4-bit one share stimulus.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] npc;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_ready;

  logic [31:0] pc_o, imem_addr, if_instr;
  logic        imem_req, if_valid, fetch_err;
  logic [31:0] retired_cnt;

  logic [31:0] pc_o4, imem_addr4, if_instr4;
  logic        imem_req4, if_valid4, fetch_err4;
  logic [3:0]  retired_cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .npc         (npc),
    .pc_o        (pc_o),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .fetch_err   (fetch_err),
    .retired_cnt (retired_cnt)
  );

  ifetch_unit #(
    .CNT_W (4)
  ) dut4 (
    .clk         (clk),
    .rstn        (rstn),
    .npc         (npc),
    .pc_o        (pc_o4),
    .imem_req    (imem_req4),
    .imem_addr   (imem_addr4),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid4),
    .if_ready    (if_ready),
    .if_instr    (if_instr4),
    .fetch_err   (fetch_err4),
    .retired_cnt (retired_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn       = 1'b0;
    npc        = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    if_ready   = 1'b0;

    // Reset state
    #12;
    chk("rst_pc", pc_o, 32'h0000_3000);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_cnt", retired_cnt, 32'd0);

    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_3000);

    // Back-to-back 2-cycle fetches
    exp_pc   = 32'h0000_3000;
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("seq_req", {31'b0, imem_req}, 32'd1);
      chk("seq_pc", pc_o, exp_pc);
      imem_ack   = 1'b1;
      imem_rdata = 32'h2008_0005;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("seq_valid", {31'b0, if_valid}, 32'd1);
      chk("seq_instr", if_instr, 32'h2008_0005);
      npc = exp_pc + 32'd4;
      exp_pc = exp_pc + 32'd4;
      @(negedge clk);
    end
    chk("seq_cnt", retired_cnt, 32'd3);
    chk("seq_pc_end", pc_o, 32'h0000_300c);

    // Ack delayed 5 cycles
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("dly_req", {31'b0, imem_req}, 32'd1);
      chk("dly_addr", imem_addr, 32'h0000_300c);
      chk("dly_valid", {31'b0, if_valid}, 32'd0);
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'haabb_ccdd;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("dly_valid_up", {31'b0, if_valid}, 32'd1);
    chk("dly_instr", if_instr, 32'haabb_ccdd);

    // Decode stall with changing npc and stray acks
    for (int i = 0; i < 4; i++) begin
      npc        = 32'h0000_5000 + 32'(i * 8);
      imem_ack   = 1'b1;
      imem_rdata = 32'hdead_0000 + 32'(i);
      @(negedge clk);
      chk("stall_instr", if_instr, 32'haabb_ccdd);
      chk("stall_pc", pc_o, 32'h0000_300c);
      chk("stall_valid", {31'b0, if_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    if_ready = 1'b1;
    npc      = 32'h0000_3040;
    @(negedge clk);
    if_ready = 1'b0;
    chk("jump_pc", pc_o, 32'h0000_3040);
    chk("jump_req", {31'b0, imem_req}, 32'd1);
    chk("jump_cnt", retired_cnt, 32'd4);

    // Misaligned target traps
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("mis_valid", {31'b0, if_valid}, 32'd1);
    if_ready = 1'b1;
    npc      = 32'h0000_3006;
    @(negedge clk);
    chk("mis_pc", pc_o, 32'h0000_3006);
    chk("mis_err", {31'b0, fetch_err}, 32'd1);
    chk("mis_cnt", retired_cnt, 32'd5);
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_req", {31'b0, imem_req}, 32'd0);
      chk("err_valid", {31'b0, if_valid}, 32'd0);
      chk("err_sticky", {31'b0, fetch_err}, 32'd1);
      chk("err_cnt", retired_cnt, 32'd5);
      chk("err_pc", pc_o, 32'h0000_3006);
    end
    imem_ack = 1'b0;
    if_ready = 1'b0;

    // Reset out of the error state, then reset again mid-fetch with an ack pending
    rstn = 1'b0;
    #1;
    chk("rst2_err", {31'b0, fetch_err}, 32'd0);
    chk("rst2_pc", pc_o, 32'h0000_3000);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst2_req", {31'b0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0011;
    @(negedge clk);
    imem_ack = 1'b0;
    if_ready = 1'b1;
    npc      = 32'h0000_3004;
    @(negedge clk);
    if_ready = 1'b0;
    chk("pre_pc", pc_o, 32'h0000_3004);
    chk("pre_cnt", retired_cnt, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0022;
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_req", {31'b0, imem_req}, 32'd0);
    chk("mid_pc", pc_o, 32'h0000_3000);
    chk("mid_cnt", retired_cnt, 32'd0);
    chk("mid_instr", if_instr, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_req", {31'b0, imem_req}, 32'd1);
    chk("post_addr", imem_addr, 32'h0000_3000);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_valid", {31'b0, if_valid}, 32'd1);
    chk("late_instr", if_instr, 32'h0000_0022);

    // 16 handshakes wrap the 4-bit counter
    exp_pc = 32'h0000_3000;
    for (int k = 1; k <= 16; k++) begin
      if_ready = 1'b1;
      npc      = exp_pc + 32'd4;
      exp_pc   = exp_pc + 32'd4;
      @(negedge clk);
      if_ready = 1'b0;
      chk("wrap_cnt4", {28'b0, retired_cnt4}, 32'(k % 16));
      chk("wrap_pc4", pc_o4, exp_pc);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
    end
    chk("wrap_cnt32", retired_cnt, 32'd16);
    chk("wrap_valid4", {31'b0, if_valid4}, 32'd1);
    chk("wrap_err4", {31'b0, fetch_err4}, 32'd0);
    chk("wrap_pc_end", pc_o4, 32'h0000_3040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Fetch stage directly upstream of the next-PC block.
- Owns the architectural PC register and exports it as the PC input to the next-PC logic.
- Fetches the instruction at PC from instruction memory over a req/ack handshake, then presents it to decode with a valid/ready handshake.
- When decode accepts an instruction, the unit loads the next-PC result as the new PC. It also traps misaligned next-PCs and counts retired fetches.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; must be word aligned.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous, active-low reset.
- npc  input  32  next PC produced from pc_o, the current instruction and register data.
- pc_o  output  32  current PC; drives the next-PC block and decode.
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  32  read address, always equal to pc_o.
- imem_ack  input  1  read data valid this cycle.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  instruction available to decode.
- if_ready  input  1  decode consumes the instruction this cycle.
- if_instr  output  32  held instruction word.
- fetch_err  output  1  sticky misaligned-PC trap.
- retired_cnt  output  CNT_W  count of accepted instructions.

Behaviour:
- States: S_FETCH, S_HOLD, S_ERR. State register, pc, if_instr and retired_cnt are cleared or set asynchronously when rstn is low.
- Reset values:
  - state = S_FETCH
  - pc_o = RESET_PC
  - if_instr = 0
  - retired_cnt = 0
  - fetch_err = 0
  - while rstn is low: imem_req = 0, if_valid = 0
- Outputs decoded from state:
  - imem_req = (state == S_FETCH)
  - if_valid = (state == S_HOLD)
  - fetch_err = (state == S_ERR)
  - imem_addr = pc_o
- S_FETCH:
  - imem_req held high and imem_addr held stable until imem_ack.
  - On imem_ack: if_instr <= imem_rdata, then go to S_HOLD.
  - With no ack, stay in S_FETCH indefinitely; no timeout.
- S_HOLD:
  - if_instr and pc_o are held stable while if_ready is low, for any stall length.
  - On if_ready: pc_o <= npc and retired_cnt <= retired_cnt + 1.
  - After the update, next state is S_FETCH if npc[1:0] == 2'b00, else S_ERR. In the S_ERR case pc_o still loads the bad npc so it is visible for debug.
- S_ERR: terminal until rstn. No requests are issued, if_valid = 0, and if_ready is ignored.
- Latency:
  - Minimum 2 cycles per instruction: 1-cycle memory ack, then 1 cycle in S_HOLD with if_ready high.
  - The first request is asserted in the first cycle after rstn deasserts.
- Ignored inputs:
  - imem_ack outside S_FETCH is ignored, and if_instr is not disturbed.
  - if_ready outside S_HOLD is ignored.
- retired_cnt wraps from all-ones to 0 with no flag.
- npc is sampled only in the S_HOLD handshake cycle; its value at other times is irrelevant.
- Reset mid-operation: asynchronous reset during an outstanding fetch drops the request immediately. The instruction memory must tolerate an abandoned request, and any late ack after reset is treated as a fresh ack of the RESET_PC fetch only if it arrives in S_FETCH.

Decomposition:
- Shared header (the existing control-encoding include):
  - state encodings IF_S_FETCH = 2'd0, IF_S_HOLD = 2'd1, IF_S_ERR = 2'd2
  - default reset PC constant IF_RESET_PC
- One natural sub-module, fetch_pc_reg: a PC register with asynchronous reset to RESET_PC and a load enable. The parent owns the FSM, instruction holding register and counter.

Test Plan:
- Reset then a 1-cycle-ack memory returning 32'h2008_0005; hold if_ready = 1 with npc = pc_o + 4 → pc_o sequence 0x3000, 0x3004, 0x3008 at 2-cycle spacing; if_instr = 32'h2008_0005; retired_cnt = 3 after 3 handshakes.
- Memory ack delayed 5 cycles → imem_req stays high and imem_addr stays 0x3000 for all 5 cycles; if_valid rises the cycle after ack.
- Decode stall: if_ready low for 4 cycles in S_HOLD while npc changes → if_instr and pc_o unchanged; PC loads only the npc present on the if_ready cycle (e.g. 0x3040 jump target).
- Misaligned npc 32'h0000_3006 on handshake → pc_o = 0x3006, fetch_err = 1 next cycle, imem_req = 0 and if_valid = 0 thereafter; retired_cnt incremented once.
- Assert rstn low mid-S_FETCH with ack pending, release → pc_o = RESET_PC and retired_cnt = 0 immediately; the first post-reset request goes to 0x3000.
- Force retired_cnt to all-ones via CNT_W = 4 build, then perform 16 handshakes → counter wraps to 0, with no effect on fetch.
